// File: rtl/main_cmd_arbiter_pkg.sv
// main_cmd_arbiter_pkg: FSM state encoding, main_core command widths and the
// round-robin pointer helper shared by the arbiter files.
`ifndef MainCoreCMD_which_SIZE
`define MainCoreCMD_which_SIZE 4
`endif
`ifndef MainCoreCMD_SIZE
`define MainCoreCMD_SIZE 28
`endif

package main_cmd_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT  = 2'd1,
    ST_LOCKED = 2'd2
  } arb_state_e;

  localparam int unsigned ISSUED_W = 16;

  // Circular successor of idx among n requesters.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/main_cmd_arbiter_rr_pick.sv
// rr_pick: combinational circular priority encoder. The first requester at or
// after i_ptr (wrapping) wins; outputs one-hot winner and its index.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_oh,
  output logic [IW-1:0]   o_idx
);

  // Scan offsets from farthest to nearest so the nearest hit overwrites.
  always_comb begin
    int j;
    j     = 0;
    o_oh  = '0;
    o_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = (int'(i_ptr) + k) % NREQ;
      if (i_req[j]) begin
        o_oh    = '0;
        o_oh[j] = 1'b1;
        o_idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/main_cmd_arbiter.sv
// main_cmd_arbiter: round-robin arbiter in front of main_core.cmd with an
// optional grant lock for multi-command sequences.
// Optional lock-idle timeout: define MAIN_CMD_ARB_TIMEOUT_EN (adds timeout_evt).
`ifndef MainCoreCMD_which_SIZE
`define MainCoreCMD_which_SIZE 4
`endif
`ifndef MainCoreCMD_SIZE
`define MainCoreCMD_SIZE 28
`endif

module main_cmd_arbiter
  import main_cmd_arbiter_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int CMD_W   = `MainCoreCMD_which_SIZE + `MainCoreCMD_SIZE,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ*CMD_W-1:0] req_cmd,
  input  logic [NREQ-1:0]       req_hasAny,
  input  logic [NREQ-1:0]       req_lock,
  output logic [NREQ-1:0]       req_consume,
  output logic [CMD_W-1:0]      cmd,
  output logic                  cmd_hasAny,
  input  logic                  cmd_consume,
  output logic [NREQ-1:0]       grant,
  output logic [ISSUED_W-1:0]   issued
`ifdef MAIN_CMD_ARB_TIMEOUT_EN
  ,
  output logic                  timeout_evt
`endif
);

  localparam int IW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_bad_cfg
    $error("main_cmd_arbiter: unsupported NREQ or TIMEOUT");
  end

  arb_state_e          r_state;
  logic [NREQ-1:0]     r_grant;
  logic [IW-1:0]       r_owner;
  logic [IW-1:0]       r_ptr;
  logic [ISSUED_W-1:0] r_issued;

  logic [NREQ-1:0]     w_pick_oh;
  logic [IW-1:0]       w_pick_idx;
  logic                w_fwd, w_own_has, w_own_lock, w_fire, w_release, w_tmo;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .i_req (req_hasAny),
    .i_ptr (r_ptr),
    .o_oh  (w_pick_oh),
    .o_idx (w_pick_idx)
  );

  // Owner pass-through; an empty grant forwards nothing.
  assign w_fwd       = |r_grant;
  assign w_own_has   = req_hasAny[r_owner];
  assign w_own_lock  = req_lock[r_owner];
  assign cmd         = w_fwd ? req_cmd[int'(r_owner)*CMD_W +: CMD_W] : '0;
  assign cmd_hasAny  = w_fwd & w_own_has;
  assign w_fire      = cmd_hasAny & cmd_consume;
  assign req_consume = w_fire ? r_grant : '0;
  assign w_release   = (r_state == ST_LOCKED) & ~w_own_has & ~w_own_lock;
  assign grant       = r_grant;
  assign issued      = r_issued;

`ifdef MAIN_CMD_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_tcnt;

  assign w_tmo       = (r_state == ST_LOCKED) & ~w_own_has & w_own_lock &
                       (r_tcnt == TW'(TIMEOUT - 1));
  assign timeout_evt = w_tmo;

  // Count idle cycles of a locked owner; any presented command clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                   r_tcnt <= '0;
    else if (r_state != ST_LOCKED || w_own_has || w_tmo) r_tcnt <= '0;
    else                                        r_tcnt <= r_tcnt + 1'b1;
  end
`else
  assign w_tmo = 1'b0;
`endif

  // Arbitration FSM: grant, pointer and issue count updates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_grant  <= '0;
      r_owner  <= '0;
      r_ptr    <= '0;
      r_issued <= '0;
    end else begin
      if (w_fire) begin
        r_issued <= r_issued + 1'b1;
        r_ptr    <= IW'(rr_next(32'(r_owner), NREQ));
      end
      case (r_state)
        ST_IDLE: begin
          if (|req_hasAny) begin
            r_grant <= w_pick_oh;
            r_owner <= w_pick_idx;
            r_state <= ST_GRANT;
          end
        end
        ST_GRANT, ST_LOCKED: begin
          if (w_fire) begin
            if (w_own_lock) r_state <= ST_LOCKED;
            else begin
              r_state <= ST_IDLE;
              r_grant <= '0;
            end
          end else if (w_release || w_tmo) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/main_cmd_arbiter.md
# main_cmd_arbiter

Round-robin arbiter that shares the single `main_core` command port between up to NREQ command producers (host channel, microcode sequencer, self-test, and so on). It forwards one granted producer's command using the `cmd`/`cmd_hasAny`/`cmd_consume` handshake. A producer can lock the grant so that a multi-command sequence (for example a keccak absorb/squeeze pair) reaches `main_core` without interleaving. The block sits directly in front of `main_core.cmd`.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `CMD_W`, default `` `MainCoreCMD_which_SIZE+`MainCoreCMD_SIZE ``: command width.
- `TIMEOUT`, default 255: lock idle limit in cycles. Used only with the timeout feature.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_cmd`  in  NREQ*CMD_W  commands; requester i uses slice `[i*CMD_W +: CMD_W]`.
- `req_hasAny`  in  NREQ  requester i has a valid command.
- `req_lock`  in  NREQ  hold the grant after the current command is consumed.
- `req_consume`  out  NREQ  the command of requester i was accepted this cycle.
- `cmd`  out  CMD_W  to `main_core.cmd`.
- `cmd_hasAny`  out  1  to `main_core.cmd_hasAny`.
- `cmd_consume`  in  1  from `main_core.cmd_consume`.
- `grant`  out  NREQ  one-hot owner, registered; all zero when there is no owner.
- `issued`  out  16  count of consumed commands; wraps modulo 2^16.
- `timeout_evt`  out  1  single-cycle pulse when a lock is force-released. Present only with the timeout feature.

## Operation
- There are three states: IDLE, GRANT and LOCKED.
- IDLE:
  - `grant` = 0.
  - If any `req_hasAny` is set, pick the first requester at or after `ptr` in circular order (`ptr` resets to 0).
  - Register `grant` as one-hot for the winner and go to GRANT.
- GRANT:
  - `cmd` = `req_cmd` of the owner. `cmd_hasAny` = `req_hasAny` of the owner. Both are combinational pass-through.
  - When `cmd_hasAny & cmd_consume`:
    - `req_consume[owner]` = 1 in that cycle.
    - `issued` increments.
    - `ptr` becomes owner+1 mod NREQ.
    - If `req_lock[owner]` = 1, go to LOCKED. Otherwise go to IDLE.
- LOCKED:
  - The grant is held and forwarding is identical to GRANT.
  - On consume with lock still 1, stay in LOCKED.
  - On consume with lock 0, go to IDLE.
  - If `req_hasAny[owner]` = 0 and `req_lock[owner]` = 0, go to IDLE with no command issued.
- Non-owners always see `req_consume` = 0.
- Protocol rule: a requester must hold `req_hasAny` and `req_cmd` stable until it sees `req_consume`. If the owner drops `req_hasAny` in GRANT, the block stays in GRANT and outputs `cmd_hasAny` = 0.
- `cmd` drives 0 whenever `grant` = 0.
- Reset, at any time including mid-handshake, clears asynchronously: state to IDLE, `grant` = 0, `ptr` = 0, `issued` = 0, and the timeout counter = 0. Combinational outputs therefore read `cmd` = 0, `cmd_hasAny` = 0, `req_consume` = 0 and `timeout_evt` = 0.

## Timing
- A request first seen in cycle t in IDLE is granted at t+1, and `cmd_hasAny` rises at t+1.
- Unlocked traffic has one IDLE bubble per command, so the maximum rate is one command every 2 cycles.
- Locked traffic can sustain one command per cycle.
- A consume and a new request from another requester in the same cycle: the new requester is arbitrated in the following IDLE cycle.
- Fairness: after a requester is served it has the lowest priority. With all requesters requesting continuously and unlocked, each is served at least once every NREQ grants.
- `issued` wraps from 16'hFFFF to 16'h0000.

## Configuration
- `MAIN_CMD_ARB_TIMEOUT_EN` defined:
  - A counter runs while in LOCKED with `req_hasAny[owner]` = 0, and resets on any owner command.
  - When the counter reaches `TIMEOUT`, the block goes to IDLE and pulses `timeout_evt` for one cycle.
- `MAIN_CMD_ARB_TIMEOUT_EN` undefined:
  - There is no counter and no `timeout_evt` port.
  - A lock is held indefinitely until the owner releases it.

## Structure
- Shared defines header: the state encodings (IDLE = 2'd0, GRANT = 2'd1, LOCKED = 2'd2) and the `MainCoreCMD` width macros, reused from the `main_core` header.
- One sub-module, `rr_pick`: a combinational circular priority encoder. Inputs are `req[NREQ]` and `ptr`. Outputs are the one-hot winner and its index.

## Test plan
- Reset held low mid-GRANT with `cmd_hasAny` = 1: all outputs read 0 immediately. After release, `ptr` = 0, so `req_hasAny` = 4'b1010 grants requester 1 first.
- All four requesters request continuously with no locks and `cmd_consume` tied 1: the grant order is 0,1,2,3,0 with one command every 2 cycles, and `issued` = 8 after 16 cycles.
- Requester 2 sets lock and issues 3 commands back-to-back while requester 0 also requests: `cmd` shows only requester 2's commands for 3 consecutive cycles. Requester 0 is granted 2 cycles after requester 2 releases the lock.
- Owner holds `req_hasAny` while `cmd_consume` stays 0 for 10 cycles: `cmd` is stable, `req_consume` stays 0 and `issued` is unchanged.
- With `MAIN_CMD_ARB_TIMEOUT_EN` and `TIMEOUT` = 4, the owner is locked and idle: `timeout_evt` pulses 4 cycles after its last consume, `grant` returns to 0, and a pending request is granted next.
- Preload `issued` = 16'hFFFF, then issue 1 command: `issued` = 16'h0000.
